// File: rtl/window_handshake_ctrl.sv
// window_handshake_ctrl: issues a one-cycle request pulse, then accepts
// the target's ack only inside the [MIN_DLY, MAX_DLY] window measured from
// that pulse. Early acks and missing acks produce a one-cycle error pulse.
// Completions and errors are counted in saturating counters.
//
// Handshake: go is sampled only while ready is high (IDLE); a go seen in any
// other state is dropped, never queued. a_o is high for exactly one cycle per
// accepted go. b_i is only looked at while a transaction is open (ISSUE/WAIT).
// c_o is combinational from b_i in the cycle the ack lands in the window.
module window_handshake_ctrl #(
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  output logic             ready,
  output logic             a_o,
  input  logic             b_i,
  output logic             c_o,
  output logic             err_o,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  localparam logic [7:0]       MIN_K   = 8'(MIN_DLY);
  localparam logic [7:0]       MAX_K   = 8'(MAX_DLY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       k_q, k_d;
  logic [CNT_W-1:0] done_q, err_q;

  logic busy;
  logic early_ack;
  logic accept;
  logic timeout;

  // Window decode: k counts cycles since the a_o cycle (k=0 during ISSUE).
  assign busy      = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign early_ack = busy && b_i && (k_q < MIN_K);
  assign accept    = busy && b_i && (k_q >= MIN_K) && (k_q <= MAX_K);
  assign timeout   = busy && !b_i && (k_q >= MAX_K);

  // State and delay counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic; the delay counter restarts from zero on every new issue.
  always_comb begin
    state_d = state_q;
    k_d     = 8'd0;
    case (state_q)
      S_IDLE:  if (go) state_d = S_ISSUE;
      S_ISSUE,
      S_WAIT: begin
        k_d = k_q + 8'd1;
        if (early_ack || timeout) state_d = S_ERR;
        else if (accept)          state_d = S_IDLE;
        else                      state_d = S_WAIT;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pulses decoded from state, completion strobe from the live ack.
  always_comb begin
    ready = (state_q == S_IDLE);
    a_o   = (state_q == S_ISSUE);
    err_o = (state_q == S_ERR);
    c_o   = accept;
  end

  // Saturating counters; a clear overrides an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      err_q  <= '0;
    end else if (clr_cnt) begin
      done_q <= '0;
      err_q  <= '0;
    end else begin
      if (accept && (done_q != CNT_MAX))           done_q <= done_q + CNT_ONE;
      if ((state_q == S_ERR) && (err_q != CNT_MAX)) err_q <= err_q + CNT_ONE;
    end
  end

  assign done_cnt = done_q;
  assign err_cnt  = err_q;
  assign state_o  = state_q;

endmodule

// File: doc/window_handshake_ctrl.md
WINDOW_HANDSHAKE_CTRL -- requirements
Module: window_handshake_ctrl

Interface
REQ-001 Parameter MIN_DLY, default 2: earliest acceptable ack delay in cycles after the request pulse; legal range 1..MAX_DLY.
REQ-002 Parameter MAX_DLY, default 3: latest acceptable ack delay in cycles after the request pulse; legal range MIN_DLY..255.
REQ-003 Parameter CNT_W, default 16: width of the completion and error counters.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 go  input  1  host request to start one transaction; sampled only in IDLE.
REQ-007 ready  output  1  high only in IDLE.
REQ-008 a_o  output  1  request pulse to the target, one cycle wide.
REQ-009 b_i  input  1  ack from the target.
REQ-010 c_o  output  1  completion strobe, asserted in the same cycle an in-window ack is accepted.
REQ-011 err_o  output  1  one-cycle protocol-error pulse (early ack or timeout).
REQ-012 clr_cnt  input  1  synchronous clear of both counters.
REQ-013 done_cnt  output  CNT_W  count of completed transactions, saturating.
REQ-014 err_cnt  output  CNT_W  count of error pulses, saturating.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and ERR, all registered.
REQ-016 IDLE with go=1 SHALL go to ISSUE at the next edge; IDLE with go=0 SHALL stay in IDLE; b_i SHALL be ignored in IDLE.
REQ-017 In ISSUE, a_o SHALL be 1 (decoded from state, registered timing) and the delay counter k SHALL be 0; ISSUE SHALL last exactly one cycle.
REQ-018 An 8-bit counter k SHALL increment by 1 each cycle in ISSUE/WAIT, so cycle n after the a_o cycle has k=n.
REQ-019 b_i=1 at k<MIN_DLY (including the ISSUE cycle) SHALL be an early ack: next state ERR, c_o=0.
REQ-020 b_i=1 at MIN_DLY<=k<=MAX_DLY SHALL be accepted: c_o=1 combinationally in that same cycle, done_cnt+1, next state IDLE.
REQ-021 No b_i by the end of the cycle with k=MAX_DLY SHALL be a timeout: next state ERR.
REQ-022 ERR SHALL last one cycle with err_o=1 and err_cnt+1, then return to IDLE.
REQ-023 go while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-024 c_o SHALL be 1 only under REQ-020; a_o SHALL be 1 only in ISSUE; err_o SHALL be 1 only in ERR.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-026 clr_cnt=1 SHALL zero both counters at the next edge; clear SHALL win over a simultaneous increment; the FSM SHALL be unaffected.
REQ-027 Minimum go-to-go throughput SHALL be one transaction per MIN_DLY+2 cycles (IDLE, ISSUE, waits, accept).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, k=0, done_cnt=0, err_cnt=0, a_o=0, c_o=0, err_o=0 and ready=1, regardless of clk.
REQ-029 Reset asserted mid-transaction SHALL abandon that transaction with no c_o/err_o pulse and no counter change.
REQ-030 After rst_n deasserts, the first rising edge SHALL sample go normally.

Verification (MIN_DLY=2, MAX_DLY=3)
REQ-031 go=1 at cycle 0, b_i=1 at cycle 3 -> a_o=1 at cycle 1, c_o=1 at cycle 3, done_cnt=1, ready=1 at cycle 4.
REQ-032 go at 0, b_i at 4 (k=3) -> c_o=1 at 4, err_o stays 0; b_i at 2 (k=1) -> err_o=1 at 3, err_cnt=1, c_o never 1.
REQ-033 go at 0, no b_i -> err_o=1 at cycle 5, err_cnt=1, ready=1 at cycle 6; a second go at 2 is ignored (single a_o).
REQ-034 Preload err_cnt to 2^CNT_W-1 via repeated timeouts (or CNT_W=2), then one more timeout -> err_cnt holds at max; clr_cnt coincident with an error pulse -> err_cnt=0.
REQ-035 rst_n=0 at cycle 2 of a transaction, asynchronously between edges -> outputs go to reset values immediately, no c_o, counters unchanged from reset.
REQ-036 Bench SHALL bind assertions: a_o |-> ##[MIN_DLY:MAX_DLY] (b_i && c_o) or err_o, and c_o |-> b_i, with a zero violation count at the end of the test.
